id_stage: RTL and testbench

//  RV32I instruction-decode stage. Takes fetched instructions, drives reg_file read ports and decodes fields/immediates.

---
 rtl/riscv_pkg.sv | 93 +++++++++
 rtl/imm_gen.sv | 30 +++
 rtl/id_stage.sv | 216 +++++++++++++++++++++
 tb/tb_id_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared RV32I definitions for the decode/execute slice:
//   - opcode constants
//   - alu_op_t  : 4-bit ALU operation selector
//   - imm_fmt_t : immediate format selector for imm_gen
//   - id_state_t: decode-stage FSM states
//   - id_ex_t   : packed ID/EX pipeline register
//   - alu_op_from_funct(): funct3/funct7 to ALU operation mapping
// ---------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_t;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_fmt_t;

   typedef enum logic {
      S_RUN       = 1'b0,
      S_LU_BUBBLE = 1'b1
   } id_state_t;

   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   rs1_data;
      logic [XLEN-1:0]   rs2_data;
      logic [REG_AW-1:0] rs1_addr;
      logic [REG_AW-1:0] rs2_addr;
      logic [XLEN-1:0]   imm;
      logic [REG_AW-1:0] rd_addr;
      logic              rd_wr;
      alu_op_t           alu_op;
      logic              alu_src_imm;
      logic [2:0]        funct3;
      logic              mem_rd;
      logic              mem_wr;
      logic              illegal;
   } id_ex_t;

   // alt is instr[30]. SUB only exists for register-register ops; the
   // shift-right variants honour alt in both OP and OP-IMM.
   function automatic alu_op_t alu_op_from_funct(input logic [2:0] f3,
                                                 input logic       alt,
                                                 input logic       allow_sub);
      alu_op_t op;
      case (f3)
         3'b000:  op = (alt & allow_sub) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
//   Combinational RV32I immediate generator; all formats sign-extend from
//   instr[31]. IMM_NONE yields zero.
//   Ports:
//     instr  in  32  instruction word
//     fmt    in  imm_fmt_t  immediate format
//     imm    out 32  sign-extended immediate
// ---------------------------------------------------------------------------
module imm_gen
   import riscv_pkg::*;
(
   input  logic [XLEN-1:0] instr,
   input  imm_fmt_t        fmt,
   output logic [XLEN-1:0] imm
);

   always_comb begin
      imm = '0;
      case (fmt)
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'b0};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
//   RV32I decode stage: decodes the fetched instruction, reads the register
//   file combinationally, detects load-use hazards and registers the result
//   into the ID/EX pipeline register.
//
//   Handshake: fetch presents if_valid/if_instr/if_pc; the instruction is
//   taken on a rising edge where id_ready=1, otherwise fetch holds it. EX
//   takes the ID/EX register on an edge where ex_ready=1; while ex_ready=0
//   the register holds. flush overrides both and empties ID/EX.
//
//   Ports:
//     clk, nrst                 clock, synchronous active-low reset
//     if_valid/if_instr/if_pc   fetched instruction
//     id_ready                  instruction accepted this cycle
//     flush                     taken branch/jump from EX
//     rf_rd{1,2}_en/_addr       register-file read ports
//     rf_rd_data{1,2}           register-file read data
//     ex_ready                  EX consumes ID/EX this cycle
//     ex_*                      ID/EX pipeline register fields
//     stall_cnt                 saturating load-use bubble counter
//     fsm_state                 current FSM state (observability)
// ---------------------------------------------------------------------------
module id_stage
   import riscv_pkg::*;
#(
   parameter int STALL_CNT_W = 16
)(
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   if_valid,
   input  logic [XLEN-1:0]        if_instr,
   input  logic [XLEN-1:0]        if_pc,
   output logic                   id_ready,
   input  logic                   flush,
   output logic                   rf_rd1_en,
   output logic [REG_AW-1:0]      rf_rd1_addr,
   output logic                   rf_rd2_en,
   output logic [REG_AW-1:0]      rf_rd2_addr,
   input  logic [XLEN-1:0]        rf_rd_data1,
   input  logic [XLEN-1:0]        rf_rd_data2,
   input  logic                   ex_ready,
   output logic                   ex_valid,
   output logic [XLEN-1:0]        ex_pc,
   output logic [XLEN-1:0]        ex_rs1_data,
   output logic [XLEN-1:0]        ex_rs2_data,
   output logic [REG_AW-1:0]      ex_rs1_addr,
   output logic [REG_AW-1:0]      ex_rs2_addr,
   output logic [XLEN-1:0]        ex_imm,
   output logic [REG_AW-1:0]      ex_rd_addr,
   output logic                   ex_rd_wr,
   output alu_op_t                ex_alu_op,
   output logic                   ex_alu_src_imm,
   output logic [2:0]             ex_funct3,
   output logic                   ex_mem_rd,
   output logic                   ex_mem_wr,
   output logic                   ex_illegal,
   output logic [STALL_CNT_W-1:0] stall_cnt,
   output id_state_t              fsm_state
);

   logic [6:0]        opcode;
   logic [REG_AW-1:0] rs1, rs2, rd;
   imm_fmt_t          fmt;
   logic              uses_rs1, uses_rs2, writes_rd;
   logic              src_imm, mem_rd, mem_wr, illegal;
   alu_op_t           alu_op;
   logic [XLEN-1:0]   imm;
   id_ex_t            dec;
   id_ex_t            ex_q;
   logic              hazard;
   id_state_t         state, state_next;
   logic              do_bubble, do_load;

   assign opcode = if_instr[6:0];
   assign rd     = if_instr[11:7];
   assign rs1    = if_instr[19:15];
   assign rs2    = if_instr[24:20];

   // ---------------- decoder ----------------
   always_comb begin
      fmt       = IMM_NONE;
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      writes_rd = 1'b0;
      alu_op    = ALU_ADD;
      src_imm   = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      illegal   = 1'b0;
      case (opcode)
         OPC_LUI:    begin fmt = IMM_U; writes_rd = 1'b1; src_imm = 1'b1; alu_op = ALU_PASS_B; end
         OPC_AUIPC:  begin fmt = IMM_U; writes_rd = 1'b1; src_imm = 1'b1; end
         OPC_JAL:    begin fmt = IMM_J; writes_rd = 1'b1; src_imm = 1'b1; end
         OPC_JALR:   begin fmt = IMM_I; uses_rs1 = 1'b1; writes_rd = 1'b1; src_imm = 1'b1; end
         OPC_BRANCH: begin fmt = IMM_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1; alu_op = ALU_SUB; end
         OPC_LOAD:   begin fmt = IMM_I; uses_rs1 = 1'b1; writes_rd = 1'b1; src_imm = 1'b1; mem_rd = 1'b1; end
         OPC_STORE:  begin fmt = IMM_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1; src_imm = 1'b1; mem_wr = 1'b1; end
         OPC_OP_IMM: begin
            fmt = IMM_I; uses_rs1 = 1'b1; writes_rd = 1'b1; src_imm = 1'b1;
            alu_op = alu_op_from_funct(if_instr[14:12], if_instr[30], 1'b0);
         end
         OPC_OP:     begin
            uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1;
            alu_op = alu_op_from_funct(if_instr[14:12], if_instr[30], 1'b1);
         end
         OPC_FENCE, OPC_SYSTEM: begin end  // architectural NOP here
         default:    illegal = 1'b1;
      endcase
   end

   imm_gen u_imm_gen (
      .instr (if_instr),
      .fmt   (fmt),
      .imm   (imm)
   );

   assign rf_rd1_en   = nrst & if_valid & uses_rs1;
   assign rf_rd2_en   = nrst & if_valid & uses_rs2;
   assign rf_rd1_addr = rs1;
   assign rf_rd2_addr = rs2;

   // Unused register indices are zeroed so the EX forwarding unit never
   // matches on stray instruction bits.
   always_comb begin
      dec             = '0;
      dec.valid       = if_valid;
      dec.pc          = if_pc;
      dec.rs1_data    = rf_rd_data1;
      dec.rs2_data    = rf_rd_data2;
      dec.rs1_addr    = uses_rs1 ? rs1 : '0;
      dec.rs2_addr    = uses_rs2 ? rs2 : '0;
      dec.imm         = imm;
      dec.rd_addr     = writes_rd ? rd : '0;
      dec.rd_wr       = writes_rd & (rd != '0);
      dec.alu_op      = alu_op;
      dec.alu_src_imm = src_imm;
      dec.funct3      = if_instr[14:12];
      dec.mem_rd      = mem_rd;
      dec.mem_wr      = mem_wr;
      dec.illegal     = illegal;
   end

   // ---------------- load-use hazard ----------------
   assign hazard = ex_q.valid & ex_q.mem_rd & (ex_q.rd_addr != '0) &
                   ((rf_rd1_en & (rs1 == ex_q.rd_addr)) |
                    (rf_rd2_en & (rs2 == ex_q.rd_addr)));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!nrst) state <= S_RUN;
      else       state <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state;
      if (flush)
         state_next = S_RUN;
      else if (ex_ready)
         state_next = (state == S_RUN && hazard) ? S_LU_BUBBLE : S_RUN;
   end

   // ---------------- FSM: outputs ----------------
   // In S_LU_BUBBLE EX holds the bubble, so the held instruction always issues.
   always_comb begin
      id_ready  = 1'b0;
      do_bubble = 1'b0;
      do_load   = 1'b0;
      if (!nrst) begin
         id_ready = 1'b0;
      end else if (flush) begin
         id_ready = 1'b1;
      end else if (!ex_ready) begin
         id_ready = 1'b0;
      end else if (state == S_RUN && hazard) begin
         do_bubble = 1'b1;
      end else begin
         id_ready = 1'b1;
         do_load  = 1'b1;
      end
   end

   // ---------------- ID/EX register and stall counter ----------------
   always_ff @(posedge clk) begin
      if (!nrst) begin
         ex_q      <= '0;
         stall_cnt <= '0;
      end else if (flush) begin
         ex_q <= '0;
      end else if (do_bubble) begin
         ex_q <= '0;
         if (stall_cnt != '1) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end else if (do_load) begin
         ex_q <= dec;
      end
   end

   assign fsm_state      = state;
   assign ex_valid       = ex_q.valid;
   assign ex_pc          = ex_q.pc;
   assign ex_rs1_data    = ex_q.rs1_data;
   assign ex_rs2_data    = ex_q.rs2_data;
   assign ex_rs1_addr    = ex_q.rs1_addr;
   assign ex_rs2_addr    = ex_q.rs2_addr;
   assign ex_imm         = ex_q.imm;
   assign ex_rd_addr     = ex_q.rd_addr;
   assign ex_rd_wr       = ex_q.rd_wr;
   assign ex_alu_op      = ex_q.alu_op;
   assign ex_alu_src_imm = ex_q.alu_src_imm;
   assign ex_funct3      = ex_q.funct3;
   assign ex_mem_rd      = ex_q.mem_rd;
   assign ex_mem_wr      = ex_q.mem_wr;
   assign ex_illegal     = ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;
  import riscv_pkg::*;

  localparam int SCW = 2;  // narrow counter so saturation is reachable

  localparam logic [31:0] I_ADDI   = 32'hFFD08293;  // addi x5,x1,-3
  localparam logic [31:0] I_LW_X6  = 32'h00012303;  // lw x6,0(x2)
  localparam logic [31:0] I_LW_X0  = 32'h00012003;  // lw x0,0(x2)
  localparam logic [31:0] I_ADD_R1 = 32'h003303B3;  // add x7,x6,x3
  localparam logic [31:0] I_ADD_R2 = 32'h006183B3;  // add x7,x3,x6
  localparam logic [31:0] I_ADD_X0 = 32'h003003B3;  // add x7,x0,x3
  localparam logic [31:0] I_ORI    = 32'hFFF4E493;  // ori x9,x9,-1

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic             if_valid, id_ready, flush, ex_ready;
  logic [31:0]      if_instr, if_pc, rf_rd_data1, rf_rd_data2;
  logic             rf_rd1_en, rf_rd2_en;
  logic [4:0]       rf_rd1_addr, rf_rd2_addr;
  logic             ex_valid, ex_rd_wr, ex_alu_src_imm, ex_mem_rd, ex_mem_wr, ex_illegal;
  logic [31:0]      ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]       ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  alu_op_t          ex_alu_op;
  logic [2:0]       ex_funct3;
  logic [SCW-1:0]   stall_cnt;
  id_state_t        fsm_state;

  id_stage #(.STALL_CNT_W(SCW)) dut (
    .clk(clk), .nrst(nrst),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .flush(flush),
    .rf_rd1_en(rf_rd1_en), .rf_rd1_addr(rf_rd1_addr),
    .rf_rd2_en(rf_rd2_en), .rf_rd2_addr(rf_rd2_addr),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_imm(ex_imm), .ex_rd_addr(ex_rd_addr), .ex_rd_wr(ex_rd_wr),
    .ex_alu_op(ex_alu_op), .ex_alu_src_imm(ex_alu_src_imm), .ex_funct3(ex_funct3),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_illegal(ex_illegal),
    .stall_cnt(stall_cnt), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2);
    if_valid    = v;
    if_instr    = ins;
    if_pc       = pc;
    rf_rd_data1 = d1;
    rf_rd_data2 = d2;
  endtask

  // Put a load of x6/x0 into EX, then present 'user' and check the cycle that follows.
  task automatic load_then(input logic [31:0] ld, input logic [31:0] user,
                           input logic exp_bubble, input int exp_cnt);
    drive(1'b1, ld, 32'h200, 32'h40, 32'h0);
    tick();
    check("ld_in_ex_mem_rd", 32'(ex_mem_rd), 32'd1);
    drive(1'b1, user, 32'h204, 32'h55, 32'h66);
    #1;
    check("lu_id_ready", 32'(id_ready), 32'(!exp_bubble));
    tick();
    check("lu_ex_valid", 32'(ex_valid), 32'(!exp_bubble));
    check("lu_stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
    check("lu_state", 32'(fsm_state), exp_bubble ? 32'(S_LU_BUBBLE) : 32'(S_RUN));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        valid;
    logic [31:0] instr, d1, d2;
    logic        rd1_en, rd2_en;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_wr;
    logic [31:0] imm;
    alu_op_t     alu;
    logic        src_imm;
    logic [2:0]  f3;
    logic        mem_rd, mem_wr, ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [31:0] ins, input logic [31:0] d1,
                              input logic [31:0] d2, input logic e1, input logic e2,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic wr, input logic [31:0] imm, input alu_op_t alu,
                              input logic si, input logic [2:0] f3, input logic mr,
                              input logic mw, input logic ill);
    vec_t t;
    t.valid = v;  t.instr = ins; t.d1 = d1; t.d2 = d2; t.rd1_en = e1; t.rd2_en = e2;
    t.rs1 = rs1;  t.rs2 = rs2;   t.rd = rd; t.rd_wr = wr; t.imm = imm; t.alu = alu;
    t.src_imm = si; t.f3 = f3;   t.mem_rd = mr; t.mem_wr = mw; t.ill = ill;
    return t;
  endfunction

  initial begin
    //                valid instr          d1            d2            e1 e2 rs1 rs2 rd  wr imm            alu         si f3 mr mw ill
    vecs.push_back(mk(1, I_ADDI,        32'd10,       32'd0,        1, 0, 1,  0,  5,  1, 32'hFFFFFFFD, ALU_ADD,    1, 0, 0, 0, 0));
    vecs.push_back(mk(1, I_ADD_R1,      32'h11,       32'h22,       1, 1, 6,  3,  7,  1, 32'h0,        ALU_ADD,    0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h40410433,  32'd100,      32'd30,       1, 1, 2,  4,  8,  1, 32'h0,        ALU_SUB,    0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h00512423,  32'h1000,     32'hDEADBEEF, 1, 1, 2,  5,  0,  0, 32'h8,        ALU_ADD,    1, 2, 0, 1, 0));
    vecs.push_back(mk(1, 32'hFE208EE3,  32'h7,        32'h7,        1, 1, 1,  2,  0,  0, 32'hFFFFFFFC, ALU_SUB,    0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h12345537,  32'h0,        32'h0,        0, 0, 0,  0,  10, 1, 32'h12345000, ALU_PASS_B, 1, 5, 0, 0, 0));
    vecs.push_back(mk(1, 32'hFFFFF597,  32'h0,        32'h0,        0, 0, 0,  0,  11, 1, 32'hFFFFF000, ALU_ADD,    1, 7, 0, 0, 0));
    vecs.push_back(mk(1, 32'h010000EF,  32'h0,        32'h0,        0, 0, 0,  0,  1,  1, 32'h10,       ALU_ADD,    1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h00008067,  32'h2000,     32'h0,        1, 0, 1,  0,  0,  0, 32'h0,        ALU_ADD,    1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h40525193,  32'h80000000, 32'h0,        1, 0, 4,  0,  3,  1, 32'h405,      ALU_SRA,    1, 5, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0FF0000F,  32'h0,        32'h0,        0, 0, 0,  0,  0,  0, 32'h0,        ALU_ADD,    0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h00000073,  32'h0,        32'h0,        0, 0, 0,  0,  0,  0, 32'h0,        ALU_ADD,    0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0000007F,  32'h0,        32'h0,        0, 0, 0,  0,  0,  0, 32'h0,        ALU_ADD,    0, 0, 0, 0, 1));
    vecs.push_back(mk(1, I_ORI,         32'hF0,       32'h0,        1, 0, 9,  0,  9,  1, 32'hFFFFFFFF, ALU_OR,     1, 6, 0, 0, 0));
    vecs.push_back(mk(0, I_ADD_R1,      32'h0,        32'h0,        0, 0, 0,  0,  0,  0, 32'h0,        ALU_ADD,    0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h00E6F633,  32'hFF,       32'h0F,       1, 1, 13, 14, 12, 1, 32'h0,        ALU_AND,    0, 7, 0, 0, 0));

    // ---------------- reset ----------------
    nrst = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    drive(1'b1, I_ADDI, 32'h100, 32'd10, 32'd0);
    tick();
    tick();
    check("rst_id_ready",  32'(id_ready), 32'd0);
    check("rst_rd1_en",    32'(rf_rd1_en), 32'd0);
    check("rst_rd2_en",    32'(rf_rd2_en), 32'd0);
    check("rst_ex_valid",  32'(ex_valid), 32'd0);
    check("rst_ex_pc",     ex_pc, 32'd0);
    check("rst_ex_imm",    ex_imm, 32'd0);
    check("rst_ex_rs1",    ex_rs1_data, 32'd0);
    check("rst_ex_rd",     32'(ex_rd_addr), 32'd0);
    check("rst_ex_rd_wr",  32'(ex_rd_wr), 32'd0);
    check("rst_ex_alu",    32'(ex_alu_op), 32'd0);
    check("rst_ex_src",    32'(ex_alu_src_imm), 32'd0);
    check("rst_ex_mem",    32'({ex_mem_rd, ex_mem_wr, ex_illegal}), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_state",     32'(fsm_state), 32'(S_RUN));
    nrst = 1'b1;

    // ---------------- table-driven decode ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      logic [31:0] pc;
      pc = 32'h100 + 32'(i) * 4;
      drive(vecs[i].valid, vecs[i].instr, pc, vecs[i].d1, vecs[i].d2);
      #1;
      check($sformatf("v%0d_id_ready", i), 32'(id_ready), 32'd1);
      check($sformatf("v%0d_rd1_en", i), 32'(rf_rd1_en), 32'(vecs[i].rd1_en));
      check($sformatf("v%0d_rd2_en", i), 32'(rf_rd2_en), 32'(vecs[i].rd2_en));
      if (vecs[i].rd1_en) check($sformatf("v%0d_rd1_addr", i), 32'(rf_rd1_addr), 32'(vecs[i].rs1));
      if (vecs[i].rd2_en) check($sformatf("v%0d_rd2_addr", i), 32'(rf_rd2_addr), 32'(vecs[i].rs2));
      tick();
      check($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        check($sformatf("v%0d_pc", i),      ex_pc, pc);
        check($sformatf("v%0d_rs1_data", i), ex_rs1_data, vecs[i].d1);
        check($sformatf("v%0d_rs2_data", i), ex_rs2_data, vecs[i].d2);
        check($sformatf("v%0d_rs1_addr", i), 32'(ex_rs1_addr), 32'(vecs[i].rs1));
        check($sformatf("v%0d_rs2_addr", i), 32'(ex_rs2_addr), 32'(vecs[i].rs2));
        check($sformatf("v%0d_imm", i),     ex_imm, vecs[i].imm);
        check($sformatf("v%0d_rd", i),      32'(ex_rd_addr), 32'(vecs[i].rd));
        check($sformatf("v%0d_rd_wr", i),   32'(ex_rd_wr), 32'(vecs[i].rd_wr));
        check($sformatf("v%0d_alu", i),     32'(ex_alu_op), 32'(vecs[i].alu));
        check($sformatf("v%0d_src_imm", i), 32'(ex_alu_src_imm), 32'(vecs[i].src_imm));
        check($sformatf("v%0d_funct3", i),  32'(ex_funct3), 32'(vecs[i].f3));
        check($sformatf("v%0d_mem_rd", i),  32'(ex_mem_rd), 32'(vecs[i].mem_rd));
        check($sformatf("v%0d_mem_wr", i),  32'(ex_mem_wr), 32'(vecs[i].mem_wr));
        check($sformatf("v%0d_illegal", i), 32'(ex_illegal), 32'(vecs[i].ill));
      end
    end

    // ---------------- load to x0: no bubble ----------------
    load_then(I_LW_X0, I_ADD_X0, 1'b0, 0);

    // ---------------- load-use on rs1: one bubble then issue ----------------
    load_then(I_LW_X6, I_ADD_R1, 1'b1, 1);
    #1;
    check("lu1_release_ready", 32'(id_ready), 32'd1);
    tick();
    check("lu1_issue_valid", 32'(ex_valid), 32'd1);
    check("lu1_issue_rs1",   32'(ex_rs1_addr), 32'd6);
    check("lu1_issue_pc",    ex_pc, 32'h204);
    check("lu1_state",       32'(fsm_state), 32'(S_RUN));
    check("lu1_cnt_hold",    32'(stall_cnt), 32'd1);

    // ---------------- load-use on rs2 ----------------
    load_then(I_LW_X6, I_ADD_R2, 1'b1, 2);
    tick();
    check("lu2_issue_valid", 32'(ex_valid), 32'd1);
    check("lu2_issue_rs2",   32'(ex_rs2_addr), 32'd6);

    // ---------------- ex_ready stall with flush in cycle 2 ----------------
    drive(1'b1, I_ORI, 32'h300, 32'h1, 32'h0);
    tick();
    check("st_load_valid", 32'(ex_valid), 32'd1);
    ex_ready = 1'b0;
    drive(1'b1, I_ADDI, 32'h304, 32'd10, 32'd0);
    #1;
    check("st_c1_id_ready", 32'(id_ready), 32'd0);
    tick();
    check("st_c1_valid", 32'(ex_valid), 32'd1);
    check("st_c1_pc",    ex_pc, 32'h300);
    check("st_c1_imm",   ex_imm, 32'hFFFFFFFF);
    check("st_c1_rd",    32'(ex_rd_addr), 32'd9);
    flush = 1'b1;
    #1;
    check("st_c2_id_ready", 32'(id_ready), 32'd1);
    tick();
    check("st_c2_valid", 32'(ex_valid), 32'd0);
    check("st_c2_state", 32'(fsm_state), 32'(S_RUN));
    flush = 1'b0;
    #1;
    check("st_c3_id_ready", 32'(id_ready), 32'd0);
    tick();
    check("st_c3_valid", 32'(ex_valid), 32'd0);
    ex_ready = 1'b1;

    // ---------------- flush while in the bubble state ----------------
    load_then(I_LW_X6, I_ADD_R1, 1'b1, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fb_valid", 32'(ex_valid), 32'd0);
    check("fb_state", 32'(fsm_state), 32'(S_RUN));
    check("fb_cnt",   32'(stall_cnt), 32'd3);

    // ---------------- saturation, then reset mid-stall ----------------
    load_then(I_LW_X6, I_ADD_R1, 1'b1, 3);
    nrst = 1'b0;
    tick();
    check("rm_valid", 32'(ex_valid), 32'd0);
    check("rm_state", 32'(fsm_state), 32'(S_RUN));
    check("rm_cnt",   32'(stall_cnt), 32'd0);
    check("rm_ready", 32'(id_ready), 32'd0);
    nrst = 1'b1;
    #1;
    check("rm_post_ready", 32'(id_ready), 32'd1);
    tick();
    check("rm_post_valid", 32'(ex_valid), 32'd1);
    check("rm_post_rs1",   32'(ex_rs1_addr), 32'd6);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
